receiver_i2c: RTL
=================

// Module: receiver_i2c
// PURPOSE
//  I2C target (slave) end of the transmitter_I2C link: decodes START/STOP on SCL/SDA,
//  matches the 7-bit address, ACKs, and either captures a DATA_W-bit write word or
//  returns a DATA_W-bit read word MSB-first. Same clk domain as the master; no CDC.
// PARAMETERS
//  DATA_W   16   word width per transaction; must be a multiple of 8 (bytes = DATA_W/8)
// PORTS
//  clk        in   1       system clock (same clock as master)
//  rst        in   1       asynchronous, active-low reset
//  I2C_ADDR   in   7       own target address
//  SCL        in   1       serial clock from master
//  SDA_OUT    in   1       master's SDA drive value
//  SDA_OE     in   1       master SDA output enable (1 = master drives the line)
//  RD_DATA    in   DATA_W  word returned on a read; latched at address ACK
//  SDA_IN     out  1       target SDA drive toward master (1 = released/pull-up)
//  WR_DATA    out  DATA_W  last complete write word
//  WR_VALID   out  1       1-cycle pulse when WR_DATA updates
//  BUSY       out  1       1 from START to STOP
//  GEN_CALL   out  1       1-cycle pulse on accepted general call (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst=0): SDA_IN=1, WR_DATA=0, WR_VALID=0, BUSY=0, GEN_CALL=0,
//    state=IDLE, scl_q=1, sda_q=1, bit/byte counters=0.
//  - Line value sda = SDA_OE ? SDA_OUT : SDA_IN. scl_q/sda_q are 1-cycle delayed copies.
//  - SCL rise = SCL & !scl_q: sample sda. SCL fall = !SCL & scl_q: update SDA_IN.
//  - START = SCL & scl_q & !sda & sda_q. STOP = SCL & scl_q & sda & !sda_q.
//    START in any state -> ADDR, BUSY=1, counters cleared (repeated start allowed).
//    STOP in any state -> IDLE, BUSY=0, SDA_IN=1. START/STOP outrank bit sampling.
//  - FSM: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
//  - ADDR: shift 8 bits MSB first on SCL rise; bit0 = RNW (1 = master reads).
//    At 8th rise: match -> ADDR_ACK; mismatch -> WAIT_STOP, SDA_IN stays 1 (NACK).
//  - ADDR_ACK: SDA_IN=0 from next SCL fall to the following SCL fall. If RNW, RD_DATA
//    latched into shift reg at ACK entry; at ACK-ending fall SDA_IN = MSB, -> RD_BYTE.
//    Else -> WR_BYTE, SDA_IN=1.
//  - WR_BYTE: 8 rises shift sda in; -> WR_ACK, drive 0 for one SCL period. After the
//    last byte's ACK rise: WR_DATA <= assembled word, WR_VALID=1 for 1 clk, -> WAIT_STOP.
//    Extra bytes beyond DATA_W/8 are NACKed and discarded.
//  - RD_BYTE: next bit placed on SDA_IN at each SCL fall; after 8th fall SDA_IN=1
//    (released), -> RD_ACK. RD_ACK samples master bit on rise: 0 (ACK) and bytes
//    remain -> RD_BYTE; 1 (NACK) or last byte done -> WAIT_STOP, SDA_IN=1.
//  - WAIT_STOP: SDA_IN=1, ignore bits until STOP or START.
//  - Partial write aborted by START/STOP: WR_DATA unchanged, no WR_VALID.
//  - Reset mid-transaction: immediate return to reset values; bus released.
// CONFIGURATION
//  RECEIVER_I2C_GENCALL_EN defined: address byte 8'h00 (addr 0, RNW=0) is ACKed, data
//  written as a normal write, GEN_CALL pulses 1 clk together with WR_VALID.
//  Undefined: address 0 treated as mismatch (NACK), GEN_CALL tied 0.
// TESTING
//  1 Write: I2C_ADDR=7'h2A, master writes 16'hBEEF to 0x2A -> three ACKs (SDA_IN=0),
//    WR_DATA=16'hBEEF, WR_VALID one clk, BUSY falls at STOP.
//  2 Read: RD_DATA=16'hA55A, master reads 0x2A -> SDA_IN bits 1010_0101 0101_1010,
//    address ACK, master ACK then NACK, SDA_IN=1 after last bit.
//  3 Mismatch: master writes to 0x15 -> SDA_IN stays 1 whole frame, WR_VALID never 1.
//  4 Repeated start after first write byte, then read 0x2A -> WR_DATA unchanged,
//    read data returned correctly.
//  5 rst low mid read byte -> SDA_IN=1, BUSY=0 same cycle; next full write succeeds.
//  6 GENCALL_EN on/off: write 16'h1234 to addr 0 -> on: ACK, GEN_CALL+WR_VALID;
//    off: NACK, no pulses.

Source files
------------

// File: rtl/receiver_i2c.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : receiver_i2c                                                    |
// | Purpose  : I2C target end of the transmitter_I2C link. Decodes START/STOP, |
// |            matches the 7-bit address, ACKs, captures a DATA_W-bit write    |
// |            word or returns a DATA_W-bit read word MSB first.               |
// |            Runs in the master's clock domain (no CDC).                     |
// | Ports    : clk, rst (async, active-low)                                    |
// |            I2C_ADDR  own address      SCL/SDA_OUT/SDA_OE  master drive     |
// |            RD_DATA   read word (latched at address ACK)                    |
// |            SDA_IN    target drive (1 = released)                           |
// |            WR_DATA/WR_VALID  last complete write word + 1-clk pulse        |
// |            BUSY      START..STOP      GEN_CALL  general-call pulse         |
// | Option   : RECEIVER_I2C_GENCALL_EN enables general call (address byte 00). |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module receiver_i2c #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        I2C_ADDR,
  input  logic              SCL,
  input  logic              SDA_OUT,
  input  logic              SDA_OE,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              SDA_IN,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_VALID,
  output logic              BUSY,
  output logic              GEN_CALL
);

  localparam int BYTES = DATA_W / 8;
  localparam int BCW   = $clog2(BYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [BCW-1:0] ALL_BYTES = BCW'(BYTES);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t            state, state_d;
  logic              scl_q, sda_q;
  logic [3:0]        bit_cnt, bit_cnt_d;
  logic [BCW-1:0]    byte_cnt, byte_cnt_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic              rnw, rnw_d;
  logic              sda_in_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              wr_valid_d;
  logic              busy_d;
  logic              addr_ok;
`ifdef RECEIVER_I2C_GENCALL_EN
  logic              gen, gen_d;
  logic              gen_call_d;
`endif

  // Resolved line value: whoever has the bus decides what the wire carries.
  logic sda;
  assign sda = SDA_OE ? SDA_OUT : SDA_IN;

  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = SCL & ~scl_q;
  assign scl_fall = ~SCL & scl_q;
  assign start    = SCL & scl_q & ~sda & sda_q;
  assign stop     = SCL & scl_q & sda & ~sda_q;

  // On the 8th address rise the address field sits in sh[6:0] and RNW is on sda.
`ifdef RECEIVER_I2C_GENCALL_EN
  assign addr_ok = (sh[6:0] == 7'd0) ? ~sda : (sh[6:0] == I2C_ADDR);
`else
  assign addr_ok = (sh[6:0] != 7'd0) && (sh[6:0] == I2C_ADDR);
  assign GEN_CALL = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      rnw      <= 1'b0;
      SDA_IN   <= 1'b1;
      WR_DATA  <= '0;
      WR_VALID <= 1'b0;
      BUSY     <= 1'b0;
`ifdef RECEIVER_I2C_GENCALL_EN
      gen      <= 1'b0;
      GEN_CALL <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      scl_q    <= SCL;
      sda_q    <= sda;
      bit_cnt  <= bit_cnt_d;
      byte_cnt <= byte_cnt_d;
      sh       <= sh_d;
      rnw      <= rnw_d;
      SDA_IN   <= sda_in_d;
      WR_DATA  <= wr_data_d;
      WR_VALID <= wr_valid_d;
      BUSY     <= busy_d;
`ifdef RECEIVER_I2C_GENCALL_EN
      gen      <= gen_d;
      GEN_CALL <= gen_call_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    byte_cnt_d = byte_cnt;
    sh_d       = sh;
    rnw_d      = rnw;
    sda_in_d   = SDA_IN;
    wr_data_d  = WR_DATA;
    wr_valid_d = 1'b0;
    busy_d     = BUSY;
`ifdef RECEIVER_I2C_GENCALL_EN
    gen_d      = gen;
    gen_call_d = 1'b0;
`endif

    if (start) begin
      state_d    = ADDR;
      busy_d     = 1'b1;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sh_d       = '0;
      rnw_d      = 1'b0;
      sda_in_d   = 1'b1;
`ifdef RECEIVER_I2C_GENCALL_EN
      gen_d      = 1'b0;
`endif
    end else if (stop) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      sda_in_d   = 1'b1;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            sh_d      = {sh[DATA_W-2:0], sda};
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_d = '0;
              rnw_d     = sda;
              if (addr_ok) begin
                state_d = ADDR_ACK;
                if (sda) sh_d = RD_DATA;
`ifdef RECEIVER_I2C_GENCALL_EN
                gen_d = (sh[6:0] == 7'd0);
`endif
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        // bit_cnt = 0: waiting for the fall that starts the ACK;
        // bit_cnt = 1: waiting for the fall that ends it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_in_d  = 1'b0;
              bit_cnt_d = 4'd1;
            end else if (rnw) begin
              sda_in_d  = sh[DATA_W-1];
              sh_d      = {sh[DATA_W-2:0], 1'b0};
              bit_cnt_d = 4'd1;
              state_d   = RD_BYTE;
            end else begin
              sda_in_d  = 1'b1;
              bit_cnt_d = '0;
              state_d   = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          // First fall here ends the previous ACK.
          if (scl_fall) sda_in_d = 1'b1;
          if (scl_rise) begin
            sh_d      = {sh[DATA_W-2:0], sda};
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) sda_in_d = 1'b0;
          if (scl_rise) begin
            if (byte_cnt == LAST_BYTE) begin
              wr_data_d  = sh;
              wr_valid_d = 1'b1;
`ifdef RECEIVER_I2C_GENCALL_EN
              gen_call_d = gen;
`endif
              state_d    = WAIT_STOP;
            end else begin
              byte_cnt_d = byte_cnt + BCW'(1);
              state_d    = WR_BYTE;
            end
          end
        end
        // bit_cnt counts bits already placed on the line for this byte.
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_in_d   = 1'b1;
              bit_cnt_d  = '0;
              byte_cnt_d = byte_cnt + BCW'(1);
              state_d    = RD_ACK;
            end else begin
              sda_in_d  = sh[DATA_W-1];
              sh_d      = {sh[DATA_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda && (byte_cnt != ALL_BYTES)) state_d = RD_BYTE;
            else                                 state_d = WAIT_STOP;
          end
        end
        // A final write ACK may still be on the line; release it at the next fall
        // so SDA never moves while SCL is high.
        WAIT_STOP: begin
          if (scl_fall) sda_in_d = 1'b1;
        end
        IDLE: ;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
